// File: rtl/dac_spi_pkg.sv
// Shared constants, command codes and FSM state encoding for the DAC SPI receive endpoint.
package dac_spi_pkg;

  localparam int FRAME_BITS_DEF = 32;
  localparam int PAYLOAD_BITS   = 24;

  localparam logic [3:0] CMD_WR_N   = 4'h2;
  localparam logic [3:0] CMD_WR_UPD = 4'h3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_e;

  function automatic logic is_bank_write(input logic [3:0] cmd);
    return (cmd == CMD_WR_N) || (cmd == CMD_WR_UPD);
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchronizer for one asynchronous SPI line, plus a delayed copy for rise/fall pulses.
module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;

  // Flops load 1 so an idle-high line produces no edge when reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
      r_dly  <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_dly;
  assign o_fall = ~r_sync[SYNC_STAGES-1] & r_dly;

endmodule

// File: rtl/dac_spi_rx.sv
// Slave-mode DAC SPI frame decoder: oversampled sync/sclk/data, MSB-first, {comm,addr,data,pad}.
// Optional shadow register bank enabled by `DAC_SPI_RX_REGFILE_EN.
module dac_spi_rx
  import dac_spi_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sync,
  input  logic        spi_sclk,
  input  logic        spi_data,
  output logic [3:0]  rx_comm,
  output logic [3:0]  rx_addr,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        rx_err,
  output logic        busy,
  input  logic [3:0]  rd_addr,
  output logic [15:0] rd_data
);

  localparam int CNT_W    = $clog2(FRAME_BITS + 2);
  localparam int PAD_BITS = FRAME_BITS - PAYLOAD_BITS;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_GOOD = CNT_W'(FRAME_BITS);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_SHIFT = SHIFT;
  localparam logic [1:0] S_CHECK = CHECK;

  logic w_sync_rise, w_sync_fall, w_sclk_rise, w_data_s;
  logic w_unused_sync_lvl, w_unused_sclk_lvl, w_unused_sclk_fall;
  logic w_unused_data_rise, w_unused_data_fall;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sync (
    .clk(clk), .rst(rst), .i_async(spi_sync),
    .o_sync(w_unused_sync_lvl), .o_rise(w_sync_rise), .o_fall(w_sync_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .i_async(spi_sclk),
    .o_sync(w_unused_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_unused_sclk_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
    .clk(clk), .rst(rst), .i_async(spi_data),
    .o_sync(w_data_s), .o_rise(w_unused_data_rise), .o_fall(w_unused_data_fall)
  );

  logic [1:0]            r_state;
  logic [FRAME_BITS-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_fall_pend;
  logic [3:0]            r_rx_comm, r_rx_addr;
  logic [15:0]           r_rx_data;
  logic                  r_rx_valid, r_rx_err;
  logic                  w_good;

  assign w_good = (r_cnt == CNT_GOOD) && (r_shift[PAD_BITS-1:0] == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_fall_pend <= 1'b0;
      r_rx_comm   <= '0;
      r_rx_addr   <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_rx_err    <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_fall_pend <= 1'b0;
          if (w_sync_fall || r_fall_pend) begin
            r_state <= S_SHIFT;
            r_shift <= '0;
            r_cnt   <= '0;
          end
        end
        S_SHIFT: begin
          // Sync rise wins over a coincident sclk rise; that last edge is discarded.
          if (w_sync_rise) begin
            r_state <= S_CHECK;
          end else if (w_sclk_rise) begin
            r_shift <= {r_shift[FRAME_BITS-2:0], w_data_s};
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          r_state     <= S_IDLE;
          r_fall_pend <= w_sync_fall;
          if (w_good) begin
            r_rx_comm  <= r_shift[FRAME_BITS-1 -: 4];
            r_rx_addr  <= r_shift[FRAME_BITS-5 -: 4];
            r_rx_data  <= r_shift[FRAME_BITS-9 -: 16];
            r_rx_valid <= 1'b1;
          end else begin
            r_rx_err <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rx_comm  = r_rx_comm;
  assign rx_addr  = r_rx_addr;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign rx_err   = r_rx_err;
  assign busy     = (r_state != S_IDLE);

`ifdef DAC_SPI_RX_REGFILE_EN
  logic [15:0] r_bank [16];
  logic [15:0] r_rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 16; i++) r_bank[i] <= '0;
      r_rd_data <= '0;
    end else begin
      if (r_rx_valid && is_bank_write(r_rx_comm)) r_bank[r_rx_addr] <= r_rx_data;
      r_rd_data <= r_bank[rd_addr];
    end
  end

  assign rd_data = r_rd_data;
`else
  logic w_unused_rd_addr;
  assign w_unused_rd_addr = ^rd_addr;
  assign rd_data          = '0;
`endif

endmodule

// File: tb/tb_dac_spi_rx.sv
// Scoreboard bench for dac_spi_rx: expected frame results queued at stimulus, popped on rx pulses.
module tb_dac_spi_rx;
  import dac_spi_pkg::*;

  localparam int HALF = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_sync = 1'b1;
  logic        spi_sclk = 1'b1;
  logic        spi_data = 1'b0;
  logic [3:0]  rd_addr = 4'h0;
  logic [3:0]  rx_comm, rx_addr;
  logic [15:0] rx_data, rd_data;
  logic        rx_valid, rx_err, busy;

  dac_spi_rx #(.FRAME_BITS(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .spi_sync(spi_sync), .spi_sclk(spi_sclk), .spi_data(spi_data),
    .rx_comm(rx_comm), .rx_addr(rx_addr), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_err(rx_err), .busy(busy), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        e;
    logic [3:0]  c;
    logic [3:0]  a;
    logic [15:0] d;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [3:0]  last_c = 4'h0, last_a = 4'h0;
  logic [15:0] last_d = 16'h0;

  // Every clock wait passes through here so rx pulses are never missed.
  task automatic tick(input int n);
    exp_t e;
    repeat (n) begin
      @(negedge clk);
      if (rx_valid === 1'b1 || rx_err === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_pulse: got valid=%b err=%b comm=%h addr=%h data=%h, none expected",
                   rx_valid, rx_err, rx_comm, rx_addr, rx_data);
        end else begin
          e = exp_q.pop_front();
          if ({rx_valid, rx_err, rx_comm, rx_addr, rx_data} !== {e.v, e.e, e.c, e.a, e.d}) begin
            miscompares++;
            $display("FAIL rx_result: got valid=%b err=%b %h/%h/%h, want valid=%b err=%b %h/%h/%h",
                     rx_valid, rx_err, rx_comm, rx_addr, rx_data, e.v, e.e, e.c, e.a, e.d);
          end
        end
      end
    end
  endtask

  task automatic push_good(input logic [3:0] c, input logic [3:0] a, input logic [15:0] d);
    last_c = c; last_a = a; last_d = d;
    exp_q.push_back('{v: 1'b1, e: 1'b0, c: c, a: a, d: d});
  endtask

  task automatic push_bad();
    exp_q.push_back('{v: 1'b0, e: 1'b1, c: last_c, a: last_a, d: last_d});
  endtask

  task automatic send_bits(input logic [31:0] word, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      spi_sclk = 1'b0;
      spi_data = (i < 32) ? word[31-i] : 1'b0;
      tick(HALF);
      spi_sclk = 1'b1;
      tick(HALF);
      if (i == 0) begin
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("FAIL busy_in_frame: got %b want 1", busy);
        end
      end
    end
  endtask

  task automatic send_frame(input logic [31:0] word, input int nbits, input int gap);
    spi_sync = 1'b0;
    tick(HALF);
    send_bits(word, nbits);
    spi_sync = 1'b1;
    tick(gap);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick(1);
      n++;
    end
    tick(20);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: %0d expected results outstanding, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] c, input logic [3:0] a,
                                     input logic [15:0] d, input logic [7:0] pad);
    return {c, a, d, pad};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick(5);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      vectors++;
      if ({rx_comm, rx_addr, rx_data, rx_valid, rx_err, busy, rd_data} !== '0) begin
        miscompares++;
        $display("FAIL reset_idle: cyc %0d got comm=%h addr=%h data=%h v=%b e=%b busy=%b rd=%h want all 0",
                 i, rx_comm, rx_addr, rx_data, rx_valid, rx_err, busy, rd_data);
      end
    end
  endtask

  task automatic test_good_frame();
    push_good(4'h3, 4'h5, 16'hA5C3);
    send_frame(mk(4'h3, 4'h5, 16'hA5C3, 8'h00), 32, 2);
    wait_drain("good_frame");
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_after_frame: got %b want 0", busy);
    end
  endtask

  task automatic test_bad_count();
    push_bad();
    send_frame(mk(4'h1, 4'h9, 16'hFFFF, 8'h00), 20, 2);
    wait_drain("short_frame");
    push_bad();
    send_frame(mk(4'h1, 4'h9, 16'hFFFF, 8'h00), 33, 2);
    wait_drain("long_frame");
  endtask

  task automatic test_bad_pad();
    push_bad();
    send_frame(mk(4'h3, 4'hC, 16'h1111, 8'h10), 32, 2);
    wait_drain("bad_pad");
  endtask

  task automatic test_reset_abort();
    spi_sync = 1'b0;
    tick(HALF);
    send_bits(mk(4'h3, 4'h7, 16'hBEEF, 8'h00), 12);
    rst = 1'b1;
    spi_sync = 1'b1;
    spi_sclk = 1'b1;
    spi_data = 1'b0;
    tick(4);
    rst = 1'b0;
    last_c = 4'h0; last_a = 4'h0; last_d = 16'h0;
    tick(10);
    vectors++;
    if ({rx_comm, rx_addr, rx_data, busy} !== '0) begin
      miscompares++;
      $display("FAIL abort_state: got %h/%h/%h busy=%b want 0/0/0000 busy=0",
               rx_comm, rx_addr, rx_data, busy);
    end
    push_good(4'h2, 4'hF, 16'h0001);
    send_frame(mk(4'h2, 4'hF, 16'h0001, 8'h00), 32, 2);
    wait_drain("after_abort");
  endtask

  task automatic test_regfile();
    logic [15:0] want5, want6, wantf;
    push_good(4'h3, 4'h5, 16'h1234);
    send_frame(mk(4'h3, 4'h5, 16'h1234, 8'h00), 32, 2);
    push_good(4'h1, 4'h5, 16'hFFFF);
    send_frame(mk(4'h1, 4'h5, 16'hFFFF, 8'h00), 32, 2);
    wait_drain("regfile_frames");
`ifdef DAC_SPI_RX_REGFILE_EN
    want5 = 16'h1234; want6 = 16'h0000; wantf = 16'h0001;
`else
    want5 = 16'h0000; want6 = 16'h0000; wantf = 16'h0000;
`endif
    rd_addr = 4'h5;
    tick(2);
    vectors++;
    if (rd_data !== want5) begin
      miscompares++;
      $display("FAIL rd_addr5: got %h want %h", rd_data, want5);
    end
    rd_addr = 4'h6;
    tick(2);
    vectors++;
    if (rd_data !== want6) begin
      miscompares++;
      $display("FAIL rd_addr6: got %h want %h", rd_data, want6);
    end
    rd_addr = 4'hF;
    tick(2);
    vectors++;
    if (rd_data !== wantf) begin
      miscompares++;
      $display("FAIL rd_addrF: got %h want %h", rd_data, wantf);
    end
  endtask

  task automatic test_back_to_back();
    push_good(4'h3, 4'hA, 16'h5A5A);
    push_good(4'h2, 4'h1, 16'hC001);
    send_frame(mk(4'h3, 4'hA, 16'h5A5A, 8'h00), 32, 4);
    send_frame(mk(4'h2, 4'h1, 16'hC001, 8'h00), 32, 2);
    wait_drain("back_to_back");
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_count();
    test_bad_pad();
    test_reset_abort();
    test_regfile();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
